tcdm_to_axi_lite_bridge: RTL and testbench
==========================================

# tcdm_to_axi_lite_bridge

Converts single TCDM (XBAR_TCDM_BUS-style) slave requests into AXI4-Lite master transactions, one outstanding transaction at a time. It is the return direction of the SoC's AXI-to-TCDM bridging: it lets a TCDM master port (FC data, uDMA, debug) reach AXI-Lite peripherals or the AXI-Lite side of the peripheral bus. Write and read responses are returned to the TCDM side as a single `r_valid` pulse. AXI error responses are flagged on `r_opc`.

## Interface
- `ADDR_WIDTH`, default 32, address width on both sides.
- `DATA_WIDTH`, default 32, data width on both sides (only 32 is supported).
- `ERR_RDATA`, default 32'hBADCAB1E, value returned on `r_rdata` for a read that gets an error response.
- `clk_i`  in  1  clock; one clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `tcdm_req_i`  in  1  request valid.
- `tcdm_add_i`  in  ADDR_WIDTH  byte address.
- `tcdm_wen_i`  in  1  0 = write, 1 = read.
- `tcdm_wdata_i`  in  DATA_WIDTH  write data.
- `tcdm_be_i`  in  DATA_WIDTH/8  byte enables.
- `tcdm_gnt_o`  out  1  request accepted.
- `tcdm_r_valid_o`  out  1  response pulse.
- `tcdm_r_rdata_o`  out  DATA_WIDTH  read data.
- `tcdm_r_opc_o`  out  1  1 = error response.
- AXI-Lite master outputs: `aw_addr_o` (ADDR_WIDTH), `aw_prot_o` (3), `aw_valid_o`, `w_data_o`, `w_strb_o`, `w_valid_o`, `b_ready_o`, `ar_addr_o`, `ar_prot_o`, `ar_valid_o`, `r_ready_o`.
- AXI-Lite master inputs: `aw_ready_i`, `w_ready_i`, `b_resp_i` (2), `b_valid_i`, `ar_ready_i`, `r_data_i` (DATA_WIDTH), `r_resp_i` (2), `r_valid_i`.

## Operation
- FSM states: IDLE, WRITE, WRESP, READ, RRESP.
- **IDLE**
  - `tcdm_gnt_o = tcdm_req_i`, combinational; it is never high outside IDLE.
  - On req&gnt: register `add`, `wdata`, `be` and `wen`.
  - Go to WRITE if `wen=0`, else READ.
- **WRITE**
  - `aw_valid_o` and `w_valid_o` are both asserted on entry.
  - Each channel deasserts independently after its own handshake; a sticky flag per channel records completion.
  - When both channels have handshaken (possibly in the same cycle, possibly in either order), go to WRESP.
  - AW and W payloads are stable while valid is high.
- **WRESP**
  - `b_ready_o = 1`.
  - On `b_valid_i`: capture `r_opc = |b_resp_i` and `r_rdata = 0`, then go to IDLE.
- **READ**
  - `ar_valid_o = 1` until `ar_ready_i`, then go to RRESP.
- **RRESP**
  - `r_ready_o = 1`.
  - On `r_valid_i`: capture `r_opc = |r_resp_i` and `r_rdata = r_opc ? ERR_RDATA : r_data_i`, then go to IDLE.
- Response pulse:
  - `tcdm_r_valid_o` is a registered pulse, high exactly one cycle after the B or R handshake.
  - `tcdm_r_rdata_o` and `tcdm_r_opc_o` hold their values until the next response.
- `aw_prot_o = ar_prot_o = 3'b000`.
- `w_strb_o = be`.
- Addresses are passed through unmodified; no alignment is enforced.
- Error responses (SLVERR/DECERR) never stall the bridge; they only set `r_opc`.

## Timing
- Reset values: state IDLE; every valid/ready output 0; `tcdm_gnt_o` 0 (combinational from IDLE, so it follows `req`); `tcdm_r_valid_o` 0; `tcdm_r_rdata_o` 0; `tcdm_r_opc_o` 0; address/data registers 0.
- Minimum latency with zero-wait-state AXI, req granted in cycle 0:
  - Write: AW/W handshake in cycle 1, B in cycle 2, `r_valid` in cycle 3.
  - Read: AR in cycle 1, R in cycle 2, `r_valid` in cycle 3.
- The state is IDLE in the `r_valid` cycle, so a back-to-back request is granted in that cycle; sustained throughput is one transaction per 3 cycles.
- Valids follow AXI rules: once asserted, they stay asserted until ready. Valids never depend combinationally on ready.
- `b_ready_o` and `r_ready_o` are registered state decodes, not combinational from valid.
- A `b_valid_i` or `r_valid_i` arriving outside WRESP/RRESP is ignored (ready is 0); the protocol forbids it.
- Reset mid-transaction: the FSM returns to IDLE next edge, all valids drop, and no `r_valid` is produced. The AXI slave must be reset in the same cycle.

## Structure
- Put the `tcdm2axil_state_e` enum (IDLE, WRITE, WRESP, READ, RRESP) and the `AXI_RESP_OKAY` constant (2'b00) in `pkg_soc_interconnect`.
- No sub-module is required; a thin `tcdm_to_axi_lite_bridge_intf` wrapper may map `XBAR_TCDM_BUS.Slave` and `AXI_LITE.Master` onto the flat ports.

## Test plan
- Write 0x1A10_0004, wdata 0xDEADBEEF, be 4'hF, zero-wait slave:
  - gnt in cycle 0; AW/W with that address/data/strb in cycle 1; B OKAY in cycle 2.
  - `r_valid` in cycle 3 with `r_opc=0`, `r_rdata=0`.
- Read 0x1A10_2000, slave returns 0x12345678 OKAY after 5 wait cycles:
  - `ar_valid` held until ready.
  - `r_valid` one cycle after the R handshake with `r_rdata=0x12345678`, `r_opc=0`.
- Write with `w_ready` 3 cycles before `aw_ready`, then the reverse order:
  - Each valid drops after its own handshake.
  - Exactly one AW and one W per transaction; WRESP is entered only after both.
- Read returning DECERR (2'b11):
  - `r_opc=1`, `r_rdata=0xBADCAB1E`; the next OKAY read completes normally.
- Back-to-back: `req` held high for 3 requests (W, R, W):
  - gnt is high only in IDLE cycles.
  - `r_valid` pulses in cycles 3, 6, 9; no overlap on AXI.
- Assert `rst_i` while in WRESP with `b_valid` low:
  - All outputs return to reset values next cycle; no spurious `r_valid`.
  - A following read completes correctly.

Source files
------------

// File: rtl/tcdm_to_axi_lite_bridge_pkg.sv
// Shared SoC interconnect types: bridge FSM state encoding and AXI response codes.
package pkg_soc_interconnect;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWresp,
    StRead,
    StRresp
  } tcdm2axil_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AXI-Lite has no exclusive access, so anything other than OKAY is an error.
  function automatic logic resp_is_err(logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/tcdm_to_axi_lite_bridge_if.sv
// AXI4-Lite bus bundle; master modport is the bridge side, slave modport the peripheral side.
interface tcdm_to_axi_lite_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_addr, aw_prot, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready,
    output ar_addr, ar_prot, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_addr, aw_prot, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready,
    input  ar_addr, ar_prot, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/tcdm_to_axi_lite_bridge_fsm.sv
// Single-outstanding TCDM-to-AXI-Lite transaction engine; all AXI and response outputs are
// registered, only the TCDM grant is combinational.
module tcdm_to_axi_lite_bridge_fsm
  import pkg_soc_interconnect::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA  = 32'hBADCAB1E
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tcdm_req_i,
  input  logic [ADDR_WIDTH-1:0]   tcdm_add_i,
  input  logic                    tcdm_wen_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
  output logic                    tcdm_gnt_o,
  output logic                    tcdm_r_valid_o,
  output logic [DATA_WIDTH-1:0]   tcdm_r_rdata_o,
  output logic                    tcdm_r_opc_o,
  tcdm_to_axi_lite_bridge_if.master axi
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  tcdm2axil_state_e      state_q, state_d;
  logic [ADDR_WIDTH-1:0] add_q, add_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BeWidth-1:0]    be_q, be_d;
  logic                  aw_valid_q, aw_valid_d;
  logic                  w_valid_q, w_valid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  b_ready_q, b_ready_d;
  logic                  ar_valid_q, ar_valid_d;
  logic                  r_ready_q, r_ready_d;
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_rdata_q, r_rdata_d;
  logic                  r_opc_q, r_opc_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, r_err;

  assign aw_hs = aw_valid_q & axi.aw_ready;
  assign w_hs  = w_valid_q & axi.w_ready;
  assign b_hs  = b_ready_q & axi.b_valid;
  assign ar_hs = ar_valid_q & axi.ar_ready;
  assign r_hs  = r_ready_q & axi.r_valid;
  assign r_err = resp_is_err(axi.r_resp);

  assign tcdm_gnt_o = (state_q == StIdle) & tcdm_req_i;

  always_comb begin
    state_d    = state_q;
    add_d      = add_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    b_ready_d  = b_ready_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    r_valid_d  = 1'b0;
    r_rdata_d  = r_rdata_q;
    r_opc_d    = r_opc_q;

    case (state_q)
      StIdle: begin
        if (tcdm_gnt_o) begin
          add_d   = tcdm_add_i;
          wdata_d = tcdm_wdata_i;
          be_d    = tcdm_be_i;
          if (!tcdm_wen_i) begin
            state_d    = StWrite;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
          end else begin
            state_d    = StRead;
            ar_valid_d = 1'b1;
          end
        end
      end
      StWrite: begin
        // AW and W complete independently; the sticky flags remember which already went.
        if (aw_hs) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_hs) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d   = StWresp;
          b_ready_d = 1'b1;
        end
      end
      StWresp: begin
        if (b_hs) begin
          state_d   = StIdle;
          b_ready_d = 1'b0;
          r_valid_d = 1'b1;
          r_opc_d   = resp_is_err(axi.b_resp);
          r_rdata_d = '0;
        end
      end
      StRead: begin
        if (ar_hs) begin
          state_d    = StRresp;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end
      StRresp: begin
        if (r_hs) begin
          state_d   = StIdle;
          r_ready_d = 1'b0;
          r_valid_d = 1'b1;
          r_opc_d   = r_err;
          r_rdata_d = r_err ? ERR_RDATA : axi.r_data;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      add_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      r_valid_q  <= 1'b0;
      r_rdata_q  <= '0;
      r_opc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      add_q      <= add_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      b_ready_q  <= b_ready_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      r_valid_q  <= r_valid_d;
      r_rdata_q  <= r_rdata_d;
      r_opc_q    <= r_opc_d;
    end
  end

  // Payload registers only load in idle, so they are stable for the whole valid window.
  assign axi.aw_addr  = add_q;
  assign axi.aw_prot  = 3'b000;
  assign axi.aw_valid = aw_valid_q;
  assign axi.w_data   = wdata_q;
  assign axi.w_strb   = be_q;
  assign axi.w_valid  = w_valid_q;
  assign axi.b_ready  = b_ready_q;
  assign axi.ar_addr  = add_q;
  assign axi.ar_prot  = 3'b000;
  assign axi.ar_valid = ar_valid_q;
  assign axi.r_ready  = r_ready_q;

  assign tcdm_r_valid_o = r_valid_q;
  assign tcdm_r_rdata_o = r_rdata_q;
  assign tcdm_r_opc_o   = r_opc_q;

endmodule

// File: rtl/tcdm_to_axi_lite_bridge.sv
// TCDM slave to AXI4-Lite master bridge, flat-port top; the AXI side is bundled internally
// and handed to the transaction engine.
module tcdm_to_axi_lite_bridge
  import pkg_soc_interconnect::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA  = 32'hBADCAB1E
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tcdm_req_i,
  input  logic [ADDR_WIDTH-1:0]   tcdm_add_i,
  input  logic                    tcdm_wen_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
  output logic                    tcdm_gnt_o,
  output logic                    tcdm_r_valid_o,
  output logic [DATA_WIDTH-1:0]   tcdm_r_rdata_o,
  output logic                    tcdm_r_opc_o,
  output logic [ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [2:0]              aw_prot_o,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [DATA_WIDTH-1:0]   w_data_o,
  output logic [DATA_WIDTH/8-1:0] w_strb_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  input  logic [1:0]              b_resp_i,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  output logic [ADDR_WIDTH-1:0]   ar_addr_o,
  output logic [2:0]              ar_prot_o,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  input  logic [DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]              r_resp_i,
  input  logic                    r_valid_i,
  output logic                    r_ready_o
);

  tcdm_to_axi_lite_bridge_if #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) axi_bus ();

  assign aw_addr_o  = axi_bus.aw_addr;
  assign aw_prot_o  = axi_bus.aw_prot;
  assign aw_valid_o = axi_bus.aw_valid;
  assign w_data_o   = axi_bus.w_data;
  assign w_strb_o   = axi_bus.w_strb;
  assign w_valid_o  = axi_bus.w_valid;
  assign b_ready_o  = axi_bus.b_ready;
  assign ar_addr_o  = axi_bus.ar_addr;
  assign ar_prot_o  = axi_bus.ar_prot;
  assign ar_valid_o = axi_bus.ar_valid;
  assign r_ready_o  = axi_bus.r_ready;

  assign axi_bus.aw_ready = aw_ready_i;
  assign axi_bus.w_ready  = w_ready_i;
  assign axi_bus.b_resp   = b_resp_i;
  assign axi_bus.b_valid  = b_valid_i;
  assign axi_bus.ar_ready = ar_ready_i;
  assign axi_bus.r_data   = r_data_i;
  assign axi_bus.r_resp   = r_resp_i;
  assign axi_bus.r_valid  = r_valid_i;

  tcdm_to_axi_lite_bridge_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .ERR_RDATA (ERR_RDATA)
  ) u_fsm (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .tcdm_req_i    (tcdm_req_i),
    .tcdm_add_i    (tcdm_add_i),
    .tcdm_wen_i    (tcdm_wen_i),
    .tcdm_wdata_i  (tcdm_wdata_i),
    .tcdm_be_i     (tcdm_be_i),
    .tcdm_gnt_o    (tcdm_gnt_o),
    .tcdm_r_valid_o(tcdm_r_valid_o),
    .tcdm_r_rdata_o(tcdm_r_rdata_o),
    .tcdm_r_opc_o  (tcdm_r_opc_o),
    .axi           (axi_bus)
  );

endmodule

// File: tb/tb_tcdm_to_axi_lite_bridge.sv
// Directed bench: configurable-wait AXI-Lite slave, latency/handshake/payload checks.
module tb_tcdm_to_axi_lite_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wen;
  logic [31:0] add, wdata;
  logic [3:0]  be;
  logic        gnt, r_valid, r_opc;
  logic [31:0] r_rdata;

  always #5 clk = ~clk;

  tcdm_to_axi_lite_bridge_if axi ();

  tcdm_to_axi_lite_bridge dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tcdm_req_i    (req),
    .tcdm_add_i    (add),
    .tcdm_wen_i    (wen),
    .tcdm_wdata_i  (wdata),
    .tcdm_be_i     (be),
    .tcdm_gnt_o    (gnt),
    .tcdm_r_valid_o(r_valid),
    .tcdm_r_rdata_o(r_rdata),
    .tcdm_r_opc_o  (r_opc),
    .aw_addr_o     (axi.aw_addr),
    .aw_prot_o     (axi.aw_prot),
    .aw_valid_o    (axi.aw_valid),
    .aw_ready_i    (axi.aw_ready),
    .w_data_o      (axi.w_data),
    .w_strb_o      (axi.w_strb),
    .w_valid_o     (axi.w_valid),
    .w_ready_i     (axi.w_ready),
    .b_resp_i      (axi.b_resp),
    .b_valid_i     (axi.b_valid),
    .b_ready_o     (axi.b_ready),
    .ar_addr_o     (axi.ar_addr),
    .ar_prot_o     (axi.ar_prot),
    .ar_valid_o    (axi.ar_valid),
    .ar_ready_i    (axi.ar_ready),
    .r_data_i      (axi.r_data),
    .r_resp_i      (axi.r_resp),
    .r_valid_i     (axi.r_valid),
    .r_ready_o     (axi.r_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = '0;

  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0, rv_cnt = 0;
  int aw_vcyc = 0, w_vcyc = 0, ar_vcyc = 0;
  logic [31:0] seen_aw_addr = '0, seen_w_data = '0, seen_ar_addr = '0;
  logic [3:0]  seen_strb = '0;
  logic [2:0]  seen_aw_prot = '0, seen_ar_prot = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave model and handshake monitor; ready/valid update at negedge, DUT valids are registered.
  initial begin
    axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0;
    axi.b_valid = 0; axi.b_resp = 0; axi.r_valid = 0; axi.r_resp = 0; axi.r_data = 0;
    forever begin
      @(negedge clk);
      if (axi.aw_valid) begin axi.aw_ready = (aw_cnt >= aw_wait); aw_cnt++; end
      else begin axi.aw_ready = 0; aw_cnt = 0; end
      if (axi.w_valid) begin axi.w_ready = (w_cnt >= w_wait); w_cnt++; end
      else begin axi.w_ready = 0; w_cnt = 0; end
      if (axi.ar_valid) begin axi.ar_ready = (ar_cnt >= ar_wait); ar_cnt++; end
      else begin axi.ar_ready = 0; ar_cnt = 0; end
      if (axi.b_ready) begin
        axi.b_valid = (b_cnt >= b_wait); axi.b_resp = b_resp_cfg; b_cnt++;
      end else begin axi.b_valid = 0; b_cnt = 0; end
      if (axi.r_ready) begin
        axi.r_valid = (r_cnt >= r_wait); axi.r_resp = r_resp_cfg; axi.r_data = r_data_cfg;
        r_cnt++;
      end else begin axi.r_valid = 0; r_cnt = 0; end
      if (axi.aw_valid) aw_vcyc++;
      if (axi.w_valid) w_vcyc++;
      if (axi.ar_valid) ar_vcyc++;
      if (axi.aw_valid && axi.aw_ready) begin
        aw_hs++; seen_aw_addr = axi.aw_addr; seen_aw_prot = axi.aw_prot;
      end
      if (axi.w_valid && axi.w_ready) begin
        w_hs++; seen_w_data = axi.w_data; seen_strb = axi.w_strb;
      end
      if (axi.ar_valid && axi.ar_ready) begin
        ar_hs++; seen_ar_addr = axi.ar_addr; seen_ar_prot = axi.ar_prot;
      end
      if (axi.b_valid && axi.b_ready) b_hs++;
      if (axi.r_valid && axi.r_ready) r_hs++;
      if (r_valid) rv_cnt++;
    end
  end

  // One granted request; latency counted in cycles from the grant cycle to r_valid.
  task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input int exp_lat, input logic [31:0] exp_rdata,
                     input logic exp_opc);
    int lat;
    lat = 0;
    @(negedge clk);
    req = 1; wen = w; add = a; wdata = d; be = b;
    #1;
    check({tag, "_gnt"}, gnt, 1);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      req = 0;
      #1;
      if (r_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, r_rdata, exp_rdata);
    check({tag, "_opc"}, r_opc, exp_opc);
    @(negedge clk);
    #1;
    check({tag, "_pulse"}, r_valid, 0);
  endtask

  int          aw0, w0, ar0, awv0, wv0, arv0, rv0;
  int          gnt_cyc[3];
  int          rv_cyc[3];
  int          gi, nrv;
  logic [31:0] bb_rd;
  logic        bb_w[3];
  logic [31:0] bb_a[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; req = 0; wen = 1; add = '0; wdata = '0; be = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", r_valid, 0);
    check("rst_rdata", r_rdata, 0);
    check("rst_opc", r_opc, 0);
    check("rst_valids", {axi.aw_valid, axi.w_valid, axi.ar_valid}, 0);
    check("rst_readys", {axi.b_ready, axi.r_ready}, 0);
    check("rst_awaddr", axi.aw_addr, 0);
    @(negedge clk);
    rst = 0;

    // Zero-wait write
    aw0 = aw_hs; w0 = w_hs;
    txn("wr0", 0, 32'h1A10_0004, 32'hDEAD_BEEF, 4'hF, 3, 32'h0, 0);
    check("wr0_awaddr", seen_aw_addr, 32'h1A10_0004);
    check("wr0_wdata", seen_w_data, 32'hDEAD_BEEF);
    check("wr0_strb", seen_strb, 4'hF);
    check("wr0_prot", seen_aw_prot, 3'b000);
    check("wr0_nhs", (aw_hs - aw0) * 16 + (w_hs - w0), 17);

    // Read, AR stalled 2 cycles, R after 5 wait cycles
    ar_wait = 2; r_wait = 5; r_data_cfg = 32'h1234_5678;
    ar0 = ar_hs; arv0 = ar_vcyc;
    txn("rd0", 1, 32'h1A10_2000, 32'h0, 4'h0, 10, 32'h1234_5678, 0);
    check("rd0_araddr", seen_ar_addr, 32'h1A10_2000);
    check("rd0_arprot", seen_ar_prot, 3'b000);
    check("rd0_arhold", ar_vcyc - arv0, 3);
    check("rd0_nhs", ar_hs - ar0, 1);
    ar_wait = 0; r_wait = 0;

    // W accepted 3 cycles before AW, partial strobe
    aw_wait = 3; w_wait = 0;
    aw0 = aw_hs; w0 = w_hs; awv0 = aw_vcyc; wv0 = w_vcyc;
    txn("wr1", 0, 32'h1A10_0013, 32'hA5A5_0001, 4'b0110, 6, 32'h0, 0);
    check("wr1_nhs", (aw_hs - aw0) * 16 + (w_hs - w0), 17);
    check("wr1_vcyc", (aw_vcyc - awv0) * 16 + (w_vcyc - wv0), 4 * 16 + 1);
    check("wr1_strb", seen_strb, 4'b0110);
    check("wr1_awaddr", seen_aw_addr, 32'h1A10_0013);

    // AW accepted 3 cycles before W, SLVERR on B
    aw_wait = 0; w_wait = 3; b_resp_cfg = 2'b10;
    aw0 = aw_hs; w0 = w_hs; awv0 = aw_vcyc; wv0 = w_vcyc;
    txn("wr2", 0, 32'h1A10_0020, 32'h0BAD_0002, 4'hC, 6, 32'h0, 1);
    check("wr2_nhs", (aw_hs - aw0) * 16 + (w_hs - w0), 17);
    check("wr2_vcyc", (aw_vcyc - awv0) * 16 + (w_vcyc - wv0), 1 * 16 + 4);
    check("wr2_wdata", seen_w_data, 32'h0BAD_0002);
    w_wait = 0; b_resp_cfg = 2'b00;

    // DECERR read, then a clean read
    r_resp_cfg = 2'b11; r_data_cfg = 32'h55AA_55AA;
    txn("rd1", 1, 32'h1A10_3000, 32'h0, 4'h0, 3, 32'hBADC_AB1E, 1);
    r_resp_cfg = 2'b00; r_data_cfg = 32'hCAFE_F00D;
    txn("rd2", 1, 32'h1A10_3004, 32'h0, 4'h0, 3, 32'hCAFE_F00D, 0);

    // Back-to-back W, R, W with req held high
    bb_w[0] = 0; bb_a[0] = 32'h0000_0100;
    bb_w[1] = 1; bb_a[1] = 32'h0000_0200;
    bb_w[2] = 0; bb_a[2] = 32'h0000_0300;
    r_data_cfg = 32'h2222_2222;
    gi = 0; nrv = 0; bb_rd = '0;
    aw0 = aw_hs; ar0 = ar_hs;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (gi < 3) begin
        req = 1; wen = bb_w[gi]; add = bb_a[gi]; wdata = 32'h1111_0000 + bb_a[gi]; be = 4'hF;
      end else begin
        req = 0;
      end
      #1;
      if (gnt && gi < 3) begin
        gnt_cyc[gi] = c;
        gi++;
      end else if (gnt) begin
        gi++;
      end
      if (r_valid) begin
        if (nrv < 3) rv_cyc[nrv] = c;
        if (nrv == 1) bb_rd = r_rdata;
        nrv++;
      end
    end
    req = 0;
    check("bb_ngnt", gi, 3);
    check("bb_gnt_cyc", gnt_cyc[0] * 256 + gnt_cyc[1] * 16 + gnt_cyc[2], 0 * 256 + 3 * 16 + 6);
    check("bb_nrv", nrv, 3);
    check("bb_rv_cyc", rv_cyc[0] * 256 + rv_cyc[1] * 16 + rv_cyc[2], 3 * 256 + 6 * 16 + 9);
    check("bb_rdata", bb_rd, 32'h2222_2222);
    check("bb_naxi", (aw_hs - aw0) * 16 + (ar_hs - ar0), 2 * 16 + 1);

    // Reset while waiting in WRESP
    b_wait = 20;
    @(negedge clk);
    req = 1; wen = 0; add = 32'h1A10_0040; wdata = 32'h7777_7777; be = 4'hF;
    @(negedge clk);
    req = 0;
    @(negedge clk);
    #1;
    check("mr_bready", axi.b_ready, 1);
    @(negedge clk);
    rst = 1;
    rv0 = rv_cnt;
    @(negedge clk);
    #1;
    check("mr_bready0", axi.b_ready, 0);
    check("mr_valids", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.r_ready}, 0);
    check("mr_gnt", gnt, 0);
    check("mr_rvalid", r_valid, 0);
    rst = 0;
    b_wait = 0;
    repeat (5) @(negedge clk);
    #1;
    check("mr_no_rvalid", rv_cnt - rv0, 0);
    r_data_cfg = 32'h0BAD_F00D;
    txn("rd3", 1, 32'h1A10_0044, 32'h0, 4'h0, 3, 32'h0BAD_F00D, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
